// File: rtl/traffic_phase_scheduler.sv
// Four-phase intersection sequencer: latches vehicle, pedestrian and emergency requests and steps
// ALLRED -> GREEN/WALK -> YELLOW -> ALLRED. It enforces min/max green and picks phases round-robin.
module traffic_phase_scheduler #(
  parameter int MIN_GREEN = 5,
  parameter int MAX_GREEN = 30,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 10,
  parameter int TW        = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic [3:0]    req,
  input  logic          ped_btn,
  input  logic          emerg,
  input  logic [1:0]    emerg_phase,
  output logic [3:0]    grant,
  output logic [3:0]    yellow,
  output logic          all_red,
  output logic          walk,
  output logic [3:0]    pending,
  output logic          ped_pending,
  output logic [TW-1:0] timer
);

  localparam logic [1:0] S_ALLRED = 2'd0;
  localparam logic [1:0] S_GREEN  = 2'd1;
  localparam logic [1:0] S_YELLOW = 2'd2;
  localparam logic [1:0] S_WALK   = 2'd3;

  localparam logic [TW-1:0] ALLRED_END = TW'(ALLRED_T - 1);
  localparam logic [TW-1:0] YELLOW_END = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] WALK_END   = TW'(WALK_T - 1);
  localparam logic [TW-1:0] MIN_END    = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] MAX_END    = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] CNT_SAT    = TW'(MAX_GREEN);

  logic [1:0]    state, state_nxt;
  logic [1:0]    cur, cur_nxt;
  logic [1:0]    last;
  logic [TW-1:0] cnt;
  logic [3:0]    pend_nxt;
  logic          ped_nxt;
  logic [3:0]    cur_oh;
  logic          other;
  logic          trans;
  logic          green_entry;

  // First pending phase at or after 'from', wrapping 3 -> 0; only meaningful when pend != 0.
  function automatic logic [1:0] rr_pick(input logic [3:0] pend, input logic [1:0] from);
    logic [1:0] idx;
    rr_pick = from;
    for (int k = 3; k >= 0; k--) begin
      idx = from + 2'(k);
      if (pend[idx]) rr_pick = idx;
    end
  endfunction

  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    cur_oh    = 4'b0001 << cur;
    other     = (|(pending & ~cur_oh)) | ped_pending;
    case (state)
      S_ALLRED: begin
        if (tick && cnt == ALLRED_END) begin
          if (emerg) begin
            state_nxt = S_GREEN;
            cur_nxt   = emerg_phase;
          end else if (ped_pending) begin
            state_nxt = S_WALK;
          end else if (|pending) begin
            state_nxt = S_GREEN;
            cur_nxt   = rr_pick(pending, last + 2'd1);
          end else begin
            state_nxt = S_GREEN;
            cur_nxt   = 2'd0;
          end
        end
      end
      S_GREEN: begin
        // Preemption for a different phase skips tick and min-green; same phase pins green.
        if (emerg) begin
          if (emerg_phase != cur) state_nxt = S_YELLOW;
        end else if (tick && other && cnt >= MIN_END && (!req[cur] || cnt >= MAX_END)) begin
          state_nxt = S_YELLOW;
        end
      end
      S_YELLOW: begin
        if (tick && cnt == YELLOW_END) state_nxt = S_ALLRED;
      end
      default: begin
        if (emerg || (tick && cnt == WALK_END)) state_nxt = S_ALLRED;
      end
    endcase
    trans       = (state_nxt != state);
    green_entry = trans && (state_nxt == S_GREEN);

    // The served phase does not re-latch its own request while green; clear beats set.
    pend_nxt = pending | (req & ((state == S_GREEN) ? ~cur_oh : 4'hF));
    if (green_entry) pend_nxt = pend_nxt & ~(4'b0001 << cur_nxt);
    ped_nxt = (trans && state_nxt == S_WALK) ? 1'b0 : (ped_pending | ped_btn);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_ALLRED;
      cur         <= 2'd0;
      last        <= 2'd3;
      cnt         <= '0;
      pending     <= 4'b0000;
      ped_pending <= 1'b0;
    end else begin
      state       <= state_nxt;
      cur         <= cur_nxt;
      pending     <= pend_nxt;
      ped_pending <= ped_nxt;
      if (green_entry) last <= cur_nxt;
      if (trans) cnt <= '0;
      else if (tick && cnt != CNT_SAT) cnt <= cnt + 1'b1;
    end
  end

  assign grant   = (state == S_GREEN)  ? (4'b0001 << cur) : 4'b0000;
  assign yellow  = (state == S_YELLOW) ? (4'b0001 << cur) : 4'b0000;
  assign all_red = (state == S_ALLRED);
  assign walk    = (state == S_WALK);
  assign timer   = cnt;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler: expectations are queued as each step is driven and
// popped against the outputs one cycle-accurate sample later.
module tb_traffic_phase_scheduler;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic [3:0] req;
  logic       ped_btn;
  logic       emerg;
  logic [1:0] emerg_phase;
  logic [3:0] grant;
  logic [3:0] yellow;
  logic       all_red;
  logic       walk;
  logic [3:0] pending;
  logic       ped_pending;
  logic [4:0] timer;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_ent_t;

  sb_ent_t sb_q[$];
  int vectors     = 0;
  int miscompares = 0;
  int tick_div    = 1;
  int tick_cnt    = 0;

  traffic_phase_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .req         (req),
    .ped_btn     (ped_btn),
    .emerg       (emerg),
    .emerg_phase (emerg_phase),
    .grant       (grant),
    .yellow      (yellow),
    .all_red     (all_red),
    .walk        (walk),
    .pending     (pending),
    .ped_pending (ped_pending),
    .timer       (timer)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic sb_push(input string tag, input logic [31:0] exp);
    sb_ent_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    sb_ent_t e;
    vectors++;
    if (sb_q.size() == 0) begin
      miscompares++;
      $error("FAIL sb_empty: observed %0h expected queued entry", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        miscompares++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  // Advance n clocks; inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      tick_cnt++;
      tick = ((tick_cnt % tick_div) == 0);
    end
  endtask

  // Reset, release off-edge, then take the first (ticking) edge into main green.
  task automatic do_reset();
    rst_n = 1'b0;
    req = 4'b0000;
    ped_btn = 1'b0;
    emerg = 1'b0;
    emerg_phase = 2'd0;
    tick_cnt = 0;
    tick = 1'b1;
    #2;
    rst_n = 1'b1;
    cyc(1);
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    tick = 1'b1;
    req = 4'b0000;
    ped_btn = 1'b0;
    emerg = 1'b0;
    emerg_phase = 2'd0;

    // Reset state and main-phase rest with saturating timer
    sb_push("rst_all_red", 1);
    sb_push("rst_grant", 0);
    sb_push("rst_yellow", 0);
    sb_push("rst_walk", 0);
    sb_push("rst_timer", 0);
    @(posedge clk);
    #1;
    sb_check(all_red);
    sb_check(grant);
    sb_check(yellow);
    sb_check(walk);
    sb_check(timer);
    #2;
    rst_n = 1'b1;
    sb_push("rest_grant", 4'b0001);
    cyc(1);
    sb_check(grant);
    sb_push("rest_hold", 4'b0001);
    sb_push("rest_timer_sat", 30);
    cyc(100);
    sb_check(grant);
    sb_check(timer);

    // Side request ends main green after min green
    do_reset();
    req = 4'b0010;
    sb_push("t2_pending", 4'b0010);
    cyc(1);
    req = 4'b0000;
    sb_check(pending);
    sb_push("t2_grant_c4", 4'b0001);
    sb_push("t2_timer_c4", 4);
    cyc(3);
    sb_check(grant);
    sb_check(timer);
    sb_push("t2_yellow", 4'b0001);
    cyc(1);
    sb_check(yellow);
    sb_push("t2_yellow_last", 4'b0001);
    cyc(2);
    sb_check(yellow);
    sb_push("t2_all_red", 1);
    cyc(1);
    sb_check(all_red);
    sb_push("t2_grant_side", 4'b0010);
    sb_push("t2_pending_clr", 4'b0000);
    cyc(1);
    sb_check(grant);
    sb_check(pending);

    // Round-robin from last=1 over pending 1110 -> 2,3,1
    req = 4'b0100;
    cyc(1);
    req = 4'b0000;
    sb_push("rr_yellow1", 4'b0010);
    cyc(4);
    sb_check(yellow);
    req = 4'b1110;
    sb_push("rr_pending", 4'b1110);
    cyc(1);
    req = 4'b0000;
    sb_check(pending);
    sb_push("rr_grant2", 4'b0100);
    sb_push("rr_pending2", 4'b1010);
    cyc(3);
    sb_check(grant);
    sb_check(pending);
    sb_push("rr_grant3", 4'b1000);
    cyc(9);
    sb_check(grant);
    sb_push("rr_grant1", 4'b0010);
    sb_push("rr_pending_done", 4'b0000);
    cyc(9);
    sb_check(grant);
    sb_check(pending);

    // Pedestrian service from phase 2
    req = 4'b0100;
    cyc(1);
    req = 4'b0000;
    sb_push("ped_grant2", 4'b0100);
    cyc(8);
    sb_check(grant);
    ped_btn = 1'b1;
    sb_push("ped_latched", 1);
    cyc(1);
    ped_btn = 1'b0;
    sb_check(ped_pending);
    sb_push("ped_yellow", 4'b0100);
    cyc(4);
    sb_check(yellow);
    sb_push("ped_all_red", 1);
    cyc(3);
    sb_check(all_red);
    sb_push("ped_walk", 1);
    sb_push("ped_pending_clr", 0);
    cyc(1);
    sb_check(walk);
    sb_check(ped_pending);
    sb_push("ped_walk_last", 1);
    sb_push("ped_walk_timer", 9);
    cyc(9);
    sb_check(walk);
    sb_check(timer);
    sb_push("ped_all_red2", 1);
    cyc(1);
    sb_check(all_red);
    sb_push("ped_rest", 4'b0001);
    cyc(1);
    sb_check(grant);

    // Emergency preempt to phase 3, pending preserved, async reset mid-yellow
    req = 4'b0010;
    cyc(1);
    req = 4'b0000;
    emerg = 1'b1;
    emerg_phase = 2'd3;
    sb_push("em_yellow", 4'b0001);
    cyc(1);
    sb_check(yellow);
    sb_push("em_all_red", 1);
    cyc(3);
    sb_check(all_red);
    sb_push("em_grant3", 4'b1000);
    sb_push("em_pending", 4'b0010);
    cyc(1);
    sb_check(grant);
    sb_check(pending);
    sb_push("em_hold", 4'b1000);
    sb_push("em_pending_hold", 4'b0010);
    cyc(40);
    sb_check(grant);
    sb_check(pending);
    emerg = 1'b0;
    sb_push("em_release_yellow", 4'b1000);
    cyc(1);
    sb_check(yellow);
    cyc(1);
    #2;
    rst_n = 1'b0;
    sb_push("arst_all_red", 1);
    sb_push("arst_yellow", 0);
    sb_push("arst_pending", 0);
    #1;
    sb_check(all_red);
    sb_check(yellow);
    sb_check(pending);

    // Held main request stretches green to max green
    do_reset();
    req = 4'b0011;
    sb_push("max_pending", 4'b0010);
    cyc(1);
    req = 4'b0001;
    sb_check(pending);
    sb_push("max_grant_c29", 4'b0001);
    cyc(28);
    sb_check(grant);
    sb_push("max_yellow", 4'b0001);
    cyc(1);
    sb_check(yellow);
    req = 4'b0000;

    // Tick every 4th clock scales all intervals; requests latch between ticks
    tick_div = 4;
    do_reset();
    cyc(1);
    req = 4'b0010;
    sb_push("div_pending", 4'b0010);
    cyc(1);
    req = 4'b0000;
    sb_check(pending);
    sb_push("div_grant", 4'b0001);
    sb_push("div_timer", 4);
    cyc(17);
    sb_check(grant);
    sb_check(timer);
    sb_push("div_yellow", 4'b0001);
    cyc(1);
    sb_check(yellow);
    sb_push("div_yellow_last", 4'b0001);
    cyc(11);
    sb_check(yellow);
    sb_push("div_all_red", 1);
    cyc(1);
    sb_check(all_red);
    sb_push("div_all_red_last", 1);
    cyc(3);
    sb_check(all_red);
    sb_push("div_grant_side", 4'b0010);
    cyc(1);
    sb_check(grant);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
